// File: rtl/hazard_scoreboard_if.sv
// ID-stage hazard interface: instruction fields into the scoreboard, stall/forward/status out.
// master = ID stage driver, slave = hazard_scoreboard.
interface hazard_scoreboard_if #(
  parameter int unsigned REGW = 5,
  parameter int unsigned CNTW = 16,
  parameter int unsigned FSW  = 2
);
  logic            id_valid;
  logic [REGW-1:0] id_rs;
  logic [REGW-1:0] id_rt;
  logic            id_re1;
  logic            id_re2;
  logic [REGW-1:0] id_ws;
  logic            id_we;
  logic            id_is_load;
  logic            flush;
  logic            stall;
  logic [FSW-1:0]  fwd_a;
  logic [FSW-1:0]  fwd_b;
  logic [REGW-1:0] inflight;
  logic [CNTW-1:0] stall_cycles;

  modport master (
    output id_valid, id_rs, id_rt, id_re1, id_re2, id_ws, id_we, id_is_load, flush,
    input  stall, fwd_a, fwd_b, inflight, stall_cycles
  );

  modport slave (
    input  id_valid, id_rs, id_rt, id_re1, id_re2, id_ws, id_we, id_is_load, flush,
    output stall, fwd_a, fwd_b, inflight, stall_cycles
  );
endinterface

// File: rtl/hazard_scoreboard.sv
// RAW hazard unit beside ID: shadow pipeline of DEPTH in-flight writers, stall/forward decode,
// saturating stall counter. Define HAZARD_FORWARDING_EN for forwarding mode (default: full interlock).
module hazard_scoreboard #(
  parameter int unsigned DEPTH = 3,
  parameter int unsigned REGW  = 5,
  parameter int unsigned CNTW  = 16,
  parameter int unsigned FSW   = 2
) (
  input  logic               clk,
  input  logic               rst,
  hazard_scoreboard_if.slave bus
);

  typedef struct packed {
    logic            v;
    logic            we;
    logic [REGW-1:0] ws;
    logic            ld;
  } slot_t;

  slot_t            slot_q [DEPTH];
  slot_t            slot_d [DEPTH];
  logic [CNTW-1:0]  stall_cycles_q;
  logic [CNTW-1:0]  stall_cycles_d;
  logic [DEPTH-1:0] match_a_c;
  logic [DEPTH-1:0] match_b_c;
  logic             stall_c;
  logic             issue_c;
  logic [FSW-1:0]   fwd_a_c;
  logic [FSW-1:0]   fwd_b_c;
  logic [REGW-1:0]  inflight_c;
  logic             unused_ld;

  // Per-slot source matches; r0 never matches and each source has its own read enable
  always_comb begin
    match_a_c = '0;
    match_b_c = '0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      match_a_c[i] = bus.id_valid & bus.id_re1 & slot_q[i].v & slot_q[i].we
                   & (slot_q[i].ws == bus.id_rs) & (bus.id_rs != '0);
      match_b_c[i] = bus.id_valid & bus.id_re2 & slot_q[i].v & slot_q[i].we
                   & (slot_q[i].ws == bus.id_rt) & (bus.id_rt != '0);
    end
  end

`ifdef HAZARD_FORWARDING_EN
  // Only a load in EXE blocks; otherwise the youngest matching slot wins the forward mux
  always_comb begin
    stall_c = (match_a_c[0] | match_b_c[0]) & slot_q[0].ld;
    fwd_a_c = '0;
    fwd_b_c = '0;
    for (int i = int'(DEPTH) - 1; i >= 0; i--) begin
      if (match_a_c[i]) fwd_a_c = FSW'(i + 1);
      if (match_b_c[i]) fwd_b_c = FSW'(i + 1);
    end
  end
`else
  assign stall_c = |{match_a_c, match_b_c};
  assign fwd_a_c = '0;
  assign fwd_b_c = '0;
`endif

  assign issue_c = bus.id_valid & ~stall_c & ~bus.flush;

  // Shadow pipeline advance and stall counter next state
  always_comb begin
    slot_d[0] = '0;
    if (issue_c) begin
      slot_d[0] = '{v: 1'b1, we: bus.id_we, ws: bus.id_ws, ld: bus.id_is_load};
    end
    for (int i = 1; i < int'(DEPTH); i++) begin
      slot_d[i] = slot_q[i-1];
    end
    stall_cycles_d = stall_cycles_q;
    if (stall_c && (stall_cycles_q != '1)) begin
      stall_cycles_d = stall_cycles_q + CNTW'(1);
    end
  end

  // Live writer count; the ld bits beyond slot 0 only ride along
  always_comb begin
    inflight_c = '0;
    unused_ld  = 1'b0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      if (slot_q[i].v && slot_q[i].we && (slot_q[i].ws != '0)) begin
        inflight_c = inflight_c + REGW'(1);
      end
      unused_ld = unused_ld ^ slot_q[i].ld;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        slot_q[i] <= '0;
      end
      stall_cycles_q <= '0;
    end else begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        slot_q[i] <= slot_d[i];
      end
      stall_cycles_q <= stall_cycles_d;
    end
  end

  assign bus.stall        = stall_c;
  assign bus.fwd_a        = fwd_a_c;
  assign bus.fwd_b        = fwd_b_c;
  assign bus.inflight     = inflight_c;
  assign bus.stall_cycles = stall_cycles_q;

endmodule
